// File: rtl/icw_sequencer_if.sv
// CPU write port of the ICW/OCW sequencer: strobe, address bit and command byte.
// The CPU side drives (master); the sequencer samples (slave).
interface icw_sequencer_if;
  logic       write_strobe;
  logic       A0;
  logic [7:0] data_bus_in;

  modport master (
    output write_strobe,
    output A0,
    output data_bus_in
  );

  modport slave (
    input write_strobe,
    input A0,
    input data_bus_in
  );
endinterface

// File: rtl/icw_sequencer.sv
// 8259-style initialisation/operation command sequencer: walks ICW1..ICW4, then decodes
// OCW1..OCW3. All outputs are registered and change one clock after the accepted write.
module icw_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  icw_sequencer_if.slave        bus,
  output logic                  init_done,
  output logic                  level_triggered,
  output logic                  single_mode,
  output logic [4:0]            vector_base,
  output logic [7:0]            cascade_config,
  output logic                  auto_eoi,
  output logic [7:0]            interrupt_mask,
  output logic [1:0]            read_select,
  output logic                  special_mask,
  output logic                  eoi_pulse,
  output logic                  eoi_specific,
  output logic [2:0]            eoi_level,
  output logic                  poll_pulse
);

  typedef enum logic [2:0] {
    StUninit   = 3'd0,
    StWaitIcw2 = 3'd1,
    StWaitIcw3 = 3'd2,
    StWaitIcw4 = 3'd3,
    StReady    = 3'd4
  } state_e;

  state_e     state_q;
  logic       ic4_q;
  logic [7:0] d;
  logic       is_icw1;
  logic       is_cmd;
  logic       is_data;

  always_comb begin
    d       = bus.data_bus_in;
    is_icw1 = bus.write_strobe & ~bus.A0 & d[4];
    is_cmd  = bus.write_strobe & ~bus.A0 & ~d[4];
    is_data = bus.write_strobe & bus.A0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StUninit;
      ic4_q           <= 1'b0;
      init_done       <= 1'b0;
      level_triggered <= 1'b0;
      single_mode     <= 1'b0;
      vector_base     <= 5'd0;
      cascade_config  <= 8'd0;
      auto_eoi        <= 1'b0;
      interrupt_mask  <= 8'd0;
      read_select     <= 2'b10;
      special_mask    <= 1'b0;
      eoi_pulse       <= 1'b0;
      eoi_specific    <= 1'b0;
      eoi_level       <= 3'd0;
      poll_pulse      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed by a qualifying write this cycle.
      eoi_pulse  <= 1'b0;
      poll_pulse <= 1'b0;

      if (is_icw1) begin
        // ICW1 restarts the sequence from any state, including mid-sequence.
        level_triggered <= d[3];
        single_mode     <= d[1];
        ic4_q           <= d[0];
        interrupt_mask  <= 8'd0;
        cascade_config  <= 8'd0;
        auto_eoi        <= 1'b0;
        special_mask    <= 1'b0;
        read_select     <= 2'b10;
        init_done       <= 1'b0;
        state_q         <= StWaitIcw2;
      end else begin
        unique case (state_q)
          StUninit: ;
          StWaitIcw2: begin
            if (is_data) begin
              vector_base <= d[7:3];
              if (!single_mode) begin
                state_q <= StWaitIcw3;
              end else if (ic4_q) begin
                state_q <= StWaitIcw4;
              end else begin
                state_q   <= StReady;
                init_done <= 1'b1;
              end
            end
          end
          StWaitIcw3: begin
            if (is_data) begin
              cascade_config <= d;
              if (ic4_q) begin
                state_q <= StWaitIcw4;
              end else begin
                state_q   <= StReady;
                init_done <= 1'b1;
              end
            end
          end
          StWaitIcw4: begin
            if (is_data) begin
              auto_eoi  <= d[1];
              state_q   <= StReady;
              init_done <= 1'b1;
            end
          end
          StReady: begin
            if (is_data) begin
              interrupt_mask <= d;
            end else if (is_cmd && !d[3]) begin
              // OCW2: only an EOI command updates the qualifiers; others leave them held.
              if (d[5]) begin
                eoi_pulse    <= 1'b1;
                eoi_specific <= d[6];
                eoi_level    <= d[2:0];
              end
            end else if (is_cmd && d[3]) begin
              if (d[1]) read_select  <= d[1:0];
              if (d[6]) special_mask <= d[5];
              if (d[2]) poll_pulse   <= 1'b1;
            end
          end
          default: begin
            state_q   <= StUninit;
            init_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/icw_sequencer.md
ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL: write_strobe  input  1  one-cycle pulse, one CPU write accepted from bus control.
REQ-004 SHALL: A0  input  1  address bit qualifying write_strobe.
REQ-005 SHALL: data_bus_in  input  8  command word, valid while write_strobe=1.
REQ-006 SHALL: init_done  output  1  high in READY only.
REQ-007 SHALL: level_triggered  output  1  ICW1 D3 (LTIM).
REQ-008 SHALL: single_mode  output  1  ICW1 D1 (SNGL).
REQ-009 SHALL: vector_base  output  5  ICW2 D7:D3.
REQ-010 SHALL: cascade_config  output  8  ICW3 byte.
REQ-011 SHALL: auto_eoi  output  1  ICW4 D1 (AEOI).
REQ-012 SHALL: interrupt_mask  output  8  OCW1 byte.
REQ-013 SHALL: read_select  output  2  OCW3 D1:D0 (2'b10 IRR, 2'b11 ISR).
REQ-014 SHALL: special_mask  output  1  special mask mode flag.
REQ-015 SHALL: eoi_pulse  output  1  one-cycle end-of-interrupt strobe.
REQ-016 SHALL: eoi_specific  output  1  qualifier of eoi_pulse; 1 = specific EOI.
REQ-017 SHALL: eoi_level  output  3  IR level for specific EOI.
REQ-018 SHALL: poll_pulse  output  1  one-cycle poll command strobe.

Function
REQ-019 SHALL: states UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY; encoded in 3-bit register.
REQ-020 SHALL: ICW1 = write_strobe & A0=0 & D4=1; recognised in every state, including mid-sequence restart.
REQ-021 SHALL: on ICW1 latch LTIM, SNGL, IC4 (D0); clear interrupt_mask, cascade_config, auto_eoi, special_mask; set read_select=2'b10; drop init_done; next state WAIT_ICW2.
REQ-022 SHALL: in WAIT_ICW2, write with A0=1 latches vector_base; next WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-023 SHALL: in WAIT_ICW3, write with A0=1 latches cascade_config; next WAIT_ICW4 if IC4=1, else READY.
REQ-024 SHALL: in WAIT_ICW4, write with A0=1 latches auto_eoi from D1; next READY.
REQ-025 SHALL: in WAIT_ICW2/3/4, writes with A0=0 & D4=0 ignored; state unchanged.
REQ-026 SHALL: in READY, A0=1 write loads interrupt_mask (OCW1).
REQ-027 SHALL: in READY, A0=0 & D4=0 & D3=0 is OCW2: if D5=1 assert eoi_pulse for exactly one cycle, eoi_specific=D6, eoi_level=D2:D0; if D5=0 no pulse.
REQ-028 SHALL: in READY, A0=0 & D4=0 & D3=1 is OCW3: if D1=1 read_select<=D1:D0; if D6=1 special_mask<=D5; if D2=1 poll_pulse one cycle.
REQ-029 SHALL: in UNINIT, all writes other than ICW1 ignored.
REQ-030 SHALL: all outputs registered; update appears one clk after the write_strobe cycle.
REQ-031 SHALL: eoi_pulse, poll_pulse low in every cycle not directly following a qualifying write.
REQ-032 SHALL: eoi_specific, eoi_level hold last value between pulses.
REQ-033 SHALL: write_strobe held high on consecutive cycles treated as independent writes, one per cycle.

Reset
REQ-034 SHALL: reset forces UNINIT, init_done=0, all config outputs 0, read_select=2'b10, all pulses 0, one clk after assertion.
REQ-035 SHALL: reset has priority over a simultaneous write_strobe; that write is discarded.
REQ-036 SHALL: reset mid-sequence (any WAIT_ICWx) aborts; full ICW1 sequence required afterwards.

Verification
REQ-037 SHALL: reset; ICW1=0x13 (SNGL, IC4), ICW2=0x48, ICW4=0x03 -> vector_base=5'h09, auto_eoi=1, init_done=1 after third write.
REQ-038 SHALL: ICW1=0x18 (cascade, no IC4), ICW2=0x20, ICW3=0x04 -> cascade_config=0x04, init_done=1, WAIT_ICW4 skipped.
REQ-039 SHALL: READY; OCW1=0xA5 -> interrupt_mask=0xA5; then OCW2=0x63 -> eoi_pulse 1 cycle, eoi_specific=1, eoi_level=3.
REQ-040 SHALL: READY; OCW3=0x0B -> read_select=2'b11; OCW3=0x68 -> special_mask=1; OCW3=0x0C -> poll_pulse 1 cycle, read_select unchanged.
REQ-041 SHALL: ICW1=0x13 then ICW1=0x1A before ICW2 -> state WAIT_ICW2 with SNGL=1, LTIM=1, IC4=0; mask remains 0.
REQ-042 SHALL: reset asserted same cycle as OCW1=0xFF in READY -> interrupt_mask=0x00, init_done=0.
